four_b_seq_div: RTL and testbench



---
 rtl/four_b_seq_div.sv | 106 ++++++++++
 tb/tb_four_b_seq_div.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/four_b_seq_div.sv
// Sequential 4-bit unsigned restoring divider: one trial subtraction per cycle,
// one quotient bit per step, results held for the display path until the next start.
module four_b_seq_div (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] d;
    logic [3:0] v;
    logic [4:0] r;
    logic [1:0] step;

    logic [4:0] r_shift;
    logic [5:0] trial;
    logic       no_borrow;
    logic [4:0] r_next;
    logic [3:0] d_next;

    // Trial subtraction R' - V as R' + ~V + 1; the carry out means no borrow.
    always_comb begin
        r_shift   = {r[3:0], d[3]};
        trial     = {1'b0, r_shift} + {1'b0, ~{1'b0, v}} + 6'd1;
        no_borrow = trial[5];
        r_next    = no_borrow ? trial[4:0] : r_shift;
        d_next    = {d[2:0], no_borrow};
    end

    // CALC runs the first three steps; DONE runs the fourth and publishes, so its
    // closing edge raises done and the following edge can already accept a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            d           <= 4'd0;
            v           <= 4'd0;
            r           <= 5'd0;
            step        <= 2'd0;
            quotient    <= 4'd0;
            remainder   <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        d           <= dividend;
                        v           <= divisor;
                        r           <= 5'd0;
                        step        <= 2'd0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (divisor == 4'd0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    d    <= d_next;
                    r    <= r_next;
                    step <= step + 2'd1;
                    if (step == 2'd2) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (v == 4'd0) begin
                        quotient    <= 4'hF;
                        remainder   <= d;
                        div_by_zero <= 1'b1;
                    end else begin
                        d         <= d_next;
                        r         <= r_next;
                        quotient  <= d_next;
                        remainder <= r_next[3:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // The partial remainder always stays below the divisor, so bit 4 never survives a step.
    assert property (@(posedge clk) disable iff (!rst_n) (r[4] == 1'b0));

endmodule

// File: tb/tb_four_b_seq_div.sv
// Directed self-checking bench for four_b_seq_div: nominal, range edges, divide by zero,
// ignored starts, mid-operation reset and a back-to-back sweep of every operand pair.
module tb_four_b_seq_div;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int vectors;
    int miscompares;
    int overlaps;

    four_b_seq_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Present a request so the next rising edge (E0) accepts it, then scramble the operands.
    task automatic applyStimulus(input logic [3:0] dvd, input logic [3:0] dvs);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Called 1 time unit after E0; returns edges until done and cycles busy was seen high.
    task automatic waitResult(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy && done) overlaps++;
            if (done) break;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic runDivision(input string name, input logic [3:0] dvd, input logic [3:0] dvs,
                               input logic [3:0] exp_q, input logic [3:0] exp_r, input logic exp_z,
                               input int exp_lat, input int exp_busy);
        int lat;
        int busy_cnt;
        applyStimulus(dvd, dvs);
        waitResult(lat, busy_cnt);
        checkOutput({name, " latency"}, lat, exp_lat);
        checkOutput({name, " busy_cycles"}, busy_cnt, exp_busy);
        checkOutput({name, " quotient"}, quotient, exp_q);
        checkOutput({name, " remainder"}, remainder, exp_r);
        checkOutput({name, " div_by_zero"}, div_by_zero, exp_z);
    endtask

    initial begin
        int dones;
        int lat;
        int busy_cnt;
        vectors     = 0;
        miscompares = 0;
        overlaps    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        dividend    = 4'd0;
        divisor     = 4'd0;

        #12;
        checkOutput("reset quotient", quotient, 4'd0);
        checkOutput("reset remainder", remainder, 4'd0);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset div_by_zero", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        runDivision("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4, 4);
        @(posedge clk);
        #1;
        checkOutput("13/3 done_width", done, 1'b0);

        runDivision("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4, 4);
        runDivision("2/7", 4'd2, 4'd7, 4'd0, 4'd2, 1'b0, 4, 4);
        runDivision("0/5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 4, 4);
        runDivision("15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4, 4);

        runDivision("9/0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1, 1);
        applyStimulus(4'd6, 4'd2);
        checkOutput("6/2 dbz_cleared", div_by_zero, 1'b0);
        checkOutput("6/2 quotient_held", quotient, 4'hF);
        checkOutput("6/2 remainder_held", remainder, 4'd9);
        waitResult(lat, busy_cnt);
        checkOutput("6/2 latency", lat, 4);
        checkOutput("6/2 quotient", quotient, 4'd3);
        checkOutput("6/2 remainder", remainder, 4'd0);

        // Second requests land on E2 (CALC) and E4 (the final step edge).
        @(negedge clk);
        applyStimulus(4'd12, 4'd5);
        @(posedge clk);
        #1;
        dividend = 4'd1;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        dividend = 4'd1;
        divisor  = 4'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("12/5 done", done, 1'b1);
        checkOutput("12/5 quotient", quotient, 4'd2);
        checkOutput("12/5 remainder", remainder, 4'd2);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        checkOutput("ignored extra_done", dones, 0);
        checkOutput("ignored busy", busy, 1'b0);
        checkOutput("ignored quotient", quotient, 4'd2);
        checkOutput("ignored remainder", remainder, 4'd2);

        applyStimulus(4'd14, 4'd3);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset quotient", quotient, 4'd0);
        checkOutput("midreset remainder", remainder, 4'd0);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset done", done, 1'b0);
        checkOutput("midreset div_by_zero", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        checkOutput("midreset no_activity", dones, 0);
        runDivision("7/2", 4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 4, 4);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    runDivision($sformatf("sweep %0d/%0d", a, b), 4'(a), 4'(b), 4'hF, 4'(a), 1'b1, 1, 1);
                else
                    runDivision($sformatf("sweep %0d/%0d", a, b), 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0, 4, 4);
            end
        end

        checkOutput("busy_done_overlap", overlaps, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
